// File: rtl/matrix_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the LED matrix frame loader:
//   - loader_state_t : bus sequencing states of the frame loader
//   - ROW_COUNT      : row registers written per frame
//   - FRAME_COUNT    : frames in the diagonal colour animation
//   - RED/GREEN/BLUE : bit positions of the colour channels inside a nibble
// ----------------------------------------------------------------------------
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WDRAIN = 3'd2,
        ST_READ   = 3'd3,
        ST_RDRAIN = 3'd4
    } loader_state_t;

    localparam int ROW_COUNT   = 8;
    localparam int FRAME_COUNT = 7;
    localparam int NIB_W       = 4;

    localparam int RED   = 2;
    localparam int GREEN = 1;
    localparam int BLUE  = 0;

endpackage

// File: rtl/matrix_pattern_gen.sv
// ----------------------------------------------------------------------------
// matrix_pattern_gen
// Combinational generator of one 32-bit row word of the diagonal animation.
// Column c occupies nibble [4*(7-c)+3 : 4*(7-c)] with colour
// ((row + c + frame) mod 7) + 1, so every nibble is non-black and bit 3 = 0.
// Ports:
//   frame [2:0]  in   animation frame, 0..6
//   row   [2:0]  in   row register index, 0..7
//   word  [31:0] out  packed row word
// ----------------------------------------------------------------------------
module matrix_pattern_gen
    import matrix_pkg::*;
(
    input  logic [2:0]  frame,
    input  logic [2:0]  row,
    output logic [31:0] word
);

    // Build every column nibble; mod 7 is done by conditional subtraction
    // because the 5-bit sum never exceeds 21.
    always_comb begin
        logic [4:0] sum_v;
        logic [4:0] mod_v;
        logic [2:0] colour_v;
        logic [3:0] nib_v;
        word     = 32'h0000_0000;
        sum_v    = 5'd0;
        mod_v    = 5'd0;
        colour_v = 3'd0;
        nib_v    = 4'b0000;
        for (int c = 0; c < ROW_COUNT; c++) begin
            sum_v = {2'b00, row} + 5'(c) + {2'b00, frame};
            if (sum_v >= 5'd21) begin
                mod_v = sum_v - 5'd21;
            end else if (sum_v >= 5'd14) begin
                mod_v = sum_v - 5'd14;
            end else if (sum_v >= 5'd7) begin
                mod_v = sum_v - 5'd7;
            end else begin
                mod_v = sum_v;
            end
            colour_v     = 3'(mod_v + 5'd1);
            nib_v        = 4'b0000;
            nib_v[RED]   = colour_v[2];
            nib_v[GREEN] = colour_v[1];
            nib_v[BLUE]  = colour_v[0];
            word[(ROW_COUNT - 1 - c) * NIB_W +: NIB_W] = nib_v;
        end
    end

endmodule

// File: rtl/matrix_frame_loader.sv
// ----------------------------------------------------------------------------
// matrix_frame_loader
// Wishbone pipelined initiator feeding the 8-row LED matrix register slave.
// Every FRAME_PERIOD enabled cycles it writes the current animation frame to
// row registers 0..7, optionally reads them back and compares, then moves to
// the next of 7 frames. A cycle that stops receiving acks is aborted and the
// same frame is retried.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_enable              run the animation (period counter held at 0 if low)
//   i_verify              read back and compare after each write phase
//   o_wb_cyc/stb/we       wishbone cycle, strobe, write enable
//   o_wb_addr/sel/wdata   row address, byte selects, write data
//   i_wb_ack/stall/rdata  slave ack, stall, read data
//   o_frame_idx           current frame 0..6
//   o_busy                mirrors o_wb_cyc
//   o_verify_err          sticky readback mismatch
//   o_timeout             sticky ack timeout
// ----------------------------------------------------------------------------
module matrix_frame_loader
    import matrix_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 3,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int FRAME_PERIOD  = 1000000,
    parameter int ACK_TIMEOUT   = 255
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_verify,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [WB_SEL_WIDTH-1:0]  o_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_rdata,
    output logic [2:0]               o_frame_idx,
    output logic                     o_busy,
    output logic                     o_verify_err,
    output logic                     o_timeout
);

    localparam int PERIOD_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int TO_W     = $clog2(ACK_TIMEOUT + 1);

    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(FRAME_PERIOD - 1);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]          FRAME_LAST  = 3'(FRAME_COUNT - 1);
    localparam logic [3:0]          ROWS_DONE   = 4'(ROW_COUNT);

    loader_state_t           state_r;
    logic [PERIOD_W-1:0]     period_cnt_r;
    logic [3:0]              issue_cnt_r;
    logic [3:0]              ack_cnt_r;
    logic [TO_W-1:0]         to_cnt_r;
    logic [2:0]              frame_r;

    logic                     cyc_r;
    logic                     stb_r;
    logic                     we_r;
    logic [WB_ADDR_WIDTH-1:0] addr_r;
    logic [WB_SEL_WIDTH-1:0]  sel_r;
    logic [WB_DATA_WIDTH-1:0] wdata_r;
    logic                     verify_err_r;
    logic                     timeout_r;

    logic        ack_valid_s;
    logic        accept_s;
    logic [3:0]  ack_next_s;
    logic        outstanding_s;
    logic        timeout_hit_s;
    logic        rd_mismatch_s;
    logic [2:0]  wr_row_s;
    logic [2:0]  frame_next_s;
    logic [31:0] wr_word_s;
    logic [31:0] chk_word_s;

    // Word for the row about to be presented on the bus.
    matrix_pattern_gen u_wr_pattern (
        .frame (frame_r),
        .row   (wr_row_s),
        .word  (wr_word_s)
    );

    // Expected readback word for the next ack to arrive.
    matrix_pattern_gen u_chk_pattern (
        .frame (frame_r),
        .row   (ack_cnt_r[2:0]),
        .word  (chk_word_s)
    );

    // Bus handshake qualifiers and next-row selection.
    always_comb begin
        ack_valid_s   = i_wb_ack & cyc_r;
        accept_s      = stb_r & ~i_wb_stall;
        ack_next_s    = ack_cnt_r + {3'd0, ack_valid_s};
        outstanding_s = (issue_cnt_r > ack_cnt_r);
        timeout_hit_s = cyc_r & ~i_wb_ack & outstanding_s & (to_cnt_r == TO_LAST);

        if ((state_r == ST_READ) || (state_r == ST_RDRAIN)) begin
            rd_mismatch_s = ack_valid_s & (i_wb_rdata != chk_word_s);
        end else begin
            rd_mismatch_s = 1'b0;
        end

        // Leaving WAIT presents row 0; otherwise the row after the one
        // being accepted.
        if (state_r == ST_WAIT) begin
            wr_row_s = 3'd0;
        end else begin
            wr_row_s = issue_cnt_r[2:0] + 3'd1;
        end

        if (frame_r == FRAME_LAST) begin
            frame_next_s = 3'd0;
        end else begin
            frame_next_s = frame_r + 3'd1;
        end
    end

    // Loader FSM, bus counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_WAIT;
            period_cnt_r <= {PERIOD_W{1'b0}};
            issue_cnt_r  <= 4'd0;
            ack_cnt_r    <= 4'd0;
            to_cnt_r     <= {TO_W{1'b0}};
            frame_r      <= 3'd0;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= {WB_ADDR_WIDTH{1'b0}};
            sel_r        <= {WB_SEL_WIDTH{1'b0}};
            wdata_r      <= {WB_DATA_WIDTH{1'b0}};
            verify_err_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            // Bookkeeping common to every bus state; the state case below
            // overrides it when a phase starts.
            ack_cnt_r <= ack_next_s;
            if (i_wb_ack) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (cyc_r && outstanding_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
            if (rd_mismatch_s) begin
                verify_err_r <= 1'b1;
            end

            case (state_r)
                ST_WAIT: begin
                    if (!i_enable) begin
                        period_cnt_r <= {PERIOD_W{1'b0}};
                    end else if (period_cnt_r == PERIOD_LAST) begin
                        period_cnt_r <= {PERIOD_W{1'b0}};
                        issue_cnt_r  <= 4'd0;
                        ack_cnt_r    <= 4'd0;
                        to_cnt_r     <= {TO_W{1'b0}};
                        cyc_r        <= 1'b1;
                        stb_r        <= 1'b1;
                        we_r         <= 1'b1;
                        sel_r        <= {WB_SEL_WIDTH{1'b1}};
                        addr_r       <= {WB_ADDR_WIDTH{1'b0}};
                        wdata_r      <= wr_word_s;
                        state_r      <= ST_WRITE;
                    end else begin
                        period_cnt_r <= period_cnt_r + PERIOD_W'(1);
                    end
                end

                ST_WRITE, ST_READ: begin
                    if (timeout_hit_s) begin
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        we_r      <= 1'b0;
                        timeout_r <= 1'b1;
                        state_r   <= ST_WAIT;
                    end else if (accept_s) begin
                        issue_cnt_r <= issue_cnt_r + 4'd1;
                        if (issue_cnt_r == 4'd7) begin
                            stb_r   <= 1'b0;
                            state_r <= (state_r == ST_WRITE) ? ST_WDRAIN : ST_RDRAIN;
                        end else begin
                            addr_r <= WB_ADDR_WIDTH'(wr_row_s);
                            if (state_r == ST_WRITE) begin
                                wdata_r <= wr_word_s;
                            end else begin
                                wdata_r <= {WB_DATA_WIDTH{1'b0}};
                            end
                        end
                    end
                end

                ST_WDRAIN: begin
                    if (timeout_hit_s) begin
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        we_r      <= 1'b0;
                        timeout_r <= 1'b1;
                        state_r   <= ST_WAIT;
                    end else if (ack_next_s == ROWS_DONE) begin
                        if (i_verify) begin
                            // cyc stays high straight into the readback.
                            issue_cnt_r <= 4'd0;
                            ack_cnt_r   <= 4'd0;
                            to_cnt_r    <= {TO_W{1'b0}};
                            stb_r       <= 1'b1;
                            we_r        <= 1'b0;
                            addr_r      <= {WB_ADDR_WIDTH{1'b0}};
                            wdata_r     <= {WB_DATA_WIDTH{1'b0}};
                            state_r     <= ST_READ;
                        end else begin
                            cyc_r   <= 1'b0;
                            we_r    <= 1'b0;
                            frame_r <= frame_next_s;
                            state_r <= ST_WAIT;
                        end
                    end
                end

                ST_RDRAIN: begin
                    if (timeout_hit_s) begin
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        we_r      <= 1'b0;
                        timeout_r <= 1'b1;
                        state_r   <= ST_WAIT;
                    end else if (ack_next_s == ROWS_DONE) begin
                        cyc_r   <= 1'b0;
                        frame_r <= frame_next_s;
                        state_r <= ST_WAIT;
                    end
                end

                default: begin
                    cyc_r   <= 1'b0;
                    stb_r   <= 1'b0;
                    we_r    <= 1'b0;
                    state_r <= ST_WAIT;
                end
            endcase
        end
    end

    assign o_wb_cyc     = cyc_r;
    assign o_wb_stb     = stb_r;
    assign o_wb_we      = we_r;
    assign o_wb_addr    = addr_r;
    assign o_wb_sel     = sel_r;
    assign o_wb_wdata   = wdata_r;
    assign o_frame_idx  = frame_r;
    assign o_busy       = cyc_r;
    assign o_verify_err = verify_err_r;
    assign o_timeout    = timeout_r;

endmodule

// File: tb/tb_matrix_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_matrix_frame_loader
// Directed bench for matrix_frame_loader with FRAME_PERIOD=4, ACK_TIMEOUT=16.
// A memory-model wishbone slave acks one cycle after each accepted transfer
// and can stall row 2, withhold acks or corrupt row 3 readback.
// ----------------------------------------------------------------------------
module tb_matrix_frame_loader;

    logic        clk;
    logic        reset;
    logic        i_enable;
    logic        i_verify;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_wdata;
    logic        wb_ack;
    logic        wb_stall;
    logic [31:0] wb_rdata;
    logic [2:0]  o_frame_idx;
    logic        o_busy;
    logic        o_verify_err;
    logic        o_timeout;

    matrix_frame_loader #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (3),
        .WB_SEL_WIDTH  (4),
        .FRAME_PERIOD  (4),
        .ACK_TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_verify     (i_verify),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_sel     (o_wb_sel),
        .o_wb_wdata   (o_wb_wdata),
        .i_wb_ack     (wb_ack),
        .i_wb_stall   (wb_stall),
        .i_wb_rdata   (wb_rdata),
        .o_frame_idx  (o_frame_idx),
        .o_busy       (o_busy),
        .o_verify_err (o_verify_err),
        .o_timeout    (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:7];
    logic        ack_en;
    logic        corrupt;
    int          stall_req;
    int          stall_used;

    initial stall_used = 0;

    assign wb_stall = (stall_used < stall_req) && o_wb_cyc && o_wb_stb && o_wb_we
                      && (o_wb_addr == 3'd2);

    always @(posedge clk) begin
        if (o_wb_cyc && o_wb_stb && !wb_stall) begin
            if (o_wb_we) mem[o_wb_addr] <= o_wb_wdata;
            if (corrupt && o_wb_addr == 3'd3) wb_rdata <= mem[o_wb_addr] ^ 32'h0000_0001;
            else wb_rdata <= mem[o_wb_addr];
        end
        wb_ack <= o_wb_cyc && o_wb_stb && !wb_stall && ack_en;
        if (wb_stall) stall_used <= stall_used + 1;
    end

    // ---------------- monitor (cumulative counters, single writer) ----------
    int          cyc_cycles;
    int          ack_seen;
    int          stall_seen;
    int          n_acc;
    logic [2:0]  stall_addr;
    logic [31:0] stall_wdata;
    logic [2:0]  log_addr  [0:511];
    logic        log_we    [0:511];
    logic [31:0] log_wdata [0:511];
    logic [3:0]  log_sel   [0:511];

    initial begin
        cyc_cycles = 0; ack_seen = 0; stall_seen = 0; n_acc = 0;
        stall_addr = 3'd0; stall_wdata = 32'd0;
    end

    always @(negedge clk) begin
        if (o_wb_cyc) cyc_cycles = cyc_cycles + 1;
        if (o_wb_cyc && wb_ack) ack_seen = ack_seen + 1;
        if (wb_stall) begin
            stall_seen  = stall_seen + 1;
            stall_addr  = o_wb_addr;
            stall_wdata = o_wb_wdata;
        end
        if (o_wb_cyc && o_wb_stb && !wb_stall && n_acc < 512) begin
            log_addr[n_acc]  = o_wb_addr;
            log_we[n_acc]    = o_wb_we;
            log_wdata[n_acc] = o_wb_wdata;
            log_sel[n_acc]   = o_wb_sel;
            n_acc = n_acc + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Hand-computed frame-0 rows; word(f,r) only depends on (f+r) mod 7.
    function automatic logic [31:0] exp_word(input int f, input int r);
        case ((f + r) % 7)
            0:       return 32'h1234_5671;
            1:       return 32'h2345_6712;
            2:       return 32'h3456_7123;
            3:       return 32'h4567_1234;
            4:       return 32'h5671_2345;
            5:       return 32'h6712_3456;
            6:       return 32'h7123_4567;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Waits for one bus cycle (bounded) and reports its statistics.
    task automatic run_frame(output int rise_n, output int cyc_n, output int base,
                             output int acc_n, output int ack_n);
        int b_cyc;
        int b_ack;
        int n;
        b_cyc = cyc_cycles;
        b_ack = ack_seen;
        base  = n_acc;
        n = 0;
        while (!o_wb_cyc && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        rise_n = n;
        check("cyc_rise", {31'd0, o_wb_cyc}, 32'd1);
        n = 0;
        while (o_wb_cyc && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check("cyc_fall", {31'd0, o_wb_cyc}, 32'd0);
        cyc_n = cyc_cycles - b_cyc;
        acc_n = n_acc - base;
        ack_n = ack_seen - b_ack;
    endtask

    int rise_n, cyc_n, base, acc_n, ack_n, s_base, n;

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; i_enable = 1'b0; i_verify = 1'b0;
        ack_en = 1'b1; corrupt = 1'b0; stall_req = 0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        check("rst_sel", {28'd0, o_wb_sel}, 32'd0);
        check("rst_wdata", o_wb_wdata, 32'd0);
        check("rst_frame", {29'd0, o_frame_idx}, 32'd0);
        check("rst_flags", {29'd0, o_busy, o_verify_err, o_timeout}, 32'd0);

        // ---- basic write, frame 0 ----
        reset = 1'b0; i_enable = 1'b1;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t1_latency", rise_n, 32'd4);
        check("t1_cyc_len", cyc_n, 32'd9);
        check("t1_accepts", acc_n, 32'd8);
        check("t1_acks", ack_n, 32'd8);
        check("t1_sel", {28'd0, log_sel[base]}, 32'hF);
        check("t1_we", {31'd0, log_we[base]}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_addr%0d", i), {29'd0, log_addr[base+i]}, i);
            check($sformatf("t1_wdata%0d", i), log_wdata[base+i], exp_word(0, i));
        end
        check("t1_frame", {29'd0, o_frame_idx}, 32'd1);
        check("t1_busy", {31'd0, o_busy}, 32'd0);

        // ---- stall on row 2, frame 1 ----
        s_base = stall_seen;
        stall_req = 3;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t2_stall_cycles", stall_seen - s_base, 32'd3);
        check("t2_stall_addr", {29'd0, stall_addr}, 32'd2);
        check("t2_stall_wdata", stall_wdata, 32'h4567_1234);
        check("t2_cyc_len", cyc_n, 32'd12);
        check("t2_accepts", acc_n, 32'd8);
        check("t2_acks", ack_n, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_addr%0d", i), {29'd0, log_addr[base+i]}, i);
            check($sformatf("t2_wdata%0d", i), log_wdata[base+i], exp_word(1, i));
        end
        check("t2_frame", {29'd0, o_frame_idx}, 32'd2);

        // ---- write + verify, frame 2 ----
        i_verify = 1'b1;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t3_cyc_len", cyc_n, 32'd18);
        check("t3_accepts", acc_n, 32'd16);
        check("t3_acks", ack_n, 32'd16);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_wdata%0d", i), log_wdata[base+i], exp_word(2, i));
            check($sformatf("t3_rd_addr%0d", i), {29'd0, log_addr[base+8+i]}, i);
            check($sformatf("t3_rd_we%0d", i), {31'd0, log_we[base+8+i]}, 32'd0);
        end
        check("t3_verify_ok", {31'd0, o_verify_err}, 32'd0);
        check("t3_frame", {29'd0, o_frame_idx}, 32'd3);

        // ---- corrupted readback of row 3, frame 3 ----
        corrupt = 1'b1;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t3b_verify_err", {31'd0, o_verify_err}, 32'd1);
        check("t3b_frame", {29'd0, o_frame_idx}, 32'd4);
        corrupt = 1'b0; i_verify = 1'b0;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t3c_sticky", {31'd0, o_verify_err}, 32'd1);
        check("t3c_cyc_len", cyc_n, 32'd9);
        check("t3c_frame", {29'd0, o_frame_idx}, 32'd5);

        // ---- wrap: frames 5, 6, then 0 again ----
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t4_frame6", {29'd0, o_frame_idx}, 32'd6);
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t4_f6_row0", log_wdata[base], 32'h7123_4567);
        check("t4_wrap", {29'd0, o_frame_idx}, 32'd0);
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t4_f7_row0", log_wdata[base], 32'h1234_5671);
        check("t4_f7_row1", log_wdata[base+1], 32'h2345_6712);
        check("t4_after", {29'd0, o_frame_idx}, 32'd1);

        // ---- ack timeout on frame 1, then retry ----
        ack_en = 1'b0;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t5_cyc_len", cyc_n, 32'd17);
        check("t5_accepts", acc_n, 32'd8);
        check("t5_timeout", {31'd0, o_timeout}, 32'd1);
        check("t5_frame_held", {29'd0, o_frame_idx}, 32'd1);
        ack_en = 1'b1;
        run_frame(rise_n, cyc_n, base, acc_n, ack_n);
        check("t5_retry_row0", log_wdata[base], 32'h2345_6712);
        check("t5_retry_frame", {29'd0, o_frame_idx}, 32'd2);
        check("t5_sticky", {31'd0, o_timeout}, 32'd1);

        // ---- asynchronous reset during write at addr 4 ----
        n = 0;
        while (!(o_wb_cyc && o_wb_stb && o_wb_addr == 3'd4) && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t6_reach_addr4", {29'd0, o_wb_addr}, 32'd4);
        reset = 1'b1;
        #1;
        check("t6_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
        check("t6_stb_drop", {31'd0, o_wb_stb}, 32'd0);
        check("t6_busy_drop", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("t6_flags", {30'd0, o_verify_err, o_timeout}, 32'd0);
        check("t6_rst_frame", {29'd0, o_frame_idx}, 32'd0);
        reset = 1'b0;
        n = 0;
        while (!o_wb_cyc && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t6_latency", n, 32'd4);
        check("t6_addr0", {29'd0, o_wb_addr}, 32'd0);
        check("t6_wdata0", o_wb_wdata, 32'h1234_5671);
        check("t6_frame0", {29'd0, o_frame_idx}, 32'd0);
        n = 0;
        while (o_wb_cyc && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t6_after", {29'd0, o_frame_idx}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
